// File: rtl/fft16_pipelined_if.sv
// Parallel sample/bin bus of the 16-point FFT.
// The sample source is the master; the FFT engine is the slave.
interface fft16_pipelined_if #(parameter int WORD_SIZE = 16);
  logic [WORD_SIZE-1:0] in0_re, in1_re, in2_re, in3_re, in4_re, in5_re, in6_re, in7_re,
                        in8_re, in9_re, in10_re, in11_re, in12_re, in13_re, in14_re, in15_re;
  logic [WORD_SIZE-1:0] in0_im, in1_im, in2_im, in3_im, in4_im, in5_im, in6_im, in7_im,
                        in8_im, in9_im, in10_im, in11_im, in12_im, in13_im, in14_im, in15_im;
  logic [WORD_SIZE-1:0] out0_re, out1_re, out2_re, out3_re, out4_re, out5_re, out6_re, out7_re,
                        out8_re, out9_re, out10_re, out11_re, out12_re, out13_re, out14_re, out15_re;
  logic [WORD_SIZE-1:0] out0_im, out1_im, out2_im, out3_im, out4_im, out5_im, out6_im, out7_im,
                        out8_im, out9_im, out10_im, out11_im, out12_im, out13_im, out14_im, out15_im;
  logic                 o_FFT_cycle_done;

  modport master (
    output in0_re, in1_re, in2_re, in3_re, in4_re, in5_re, in6_re, in7_re,
           in8_re, in9_re, in10_re, in11_re, in12_re, in13_re, in14_re, in15_re,
           in0_im, in1_im, in2_im, in3_im, in4_im, in5_im, in6_im, in7_im,
           in8_im, in9_im, in10_im, in11_im, in12_im, in13_im, in14_im, in15_im,
    input  out0_re, out1_re, out2_re, out3_re, out4_re, out5_re, out6_re, out7_re,
           out8_re, out9_re, out10_re, out11_re, out12_re, out13_re, out14_re, out15_re,
           out0_im, out1_im, out2_im, out3_im, out4_im, out5_im, out6_im, out7_im,
           out8_im, out9_im, out10_im, out11_im, out12_im, out13_im, out14_im, out15_im,
           o_FFT_cycle_done
  );

  modport slave (
    input  in0_re, in1_re, in2_re, in3_re, in4_re, in5_re, in6_re, in7_re,
           in8_re, in9_re, in10_re, in11_re, in12_re, in13_re, in14_re, in15_re,
           in0_im, in1_im, in2_im, in3_im, in4_im, in5_im, in6_im, in7_im,
           in8_im, in9_im, in10_im, in11_im, in12_im, in13_im, in14_im, in15_im,
    output out0_re, out1_re, out2_re, out3_re, out4_re, out5_re, out6_re, out7_re,
           out8_re, out9_re, out10_re, out11_re, out12_re, out13_re, out14_re, out15_re,
           out0_im, out1_im, out2_im, out3_im, out4_im, out5_im, out6_im, out7_im,
           out8_im, out9_im, out10_im, out11_im, out12_im, out13_im, out14_im, out15_im,
           o_FFT_cycle_done
  );
endinterface

// File: rtl/fft16_pipelined.sv
// Iterative 16-point radix-2 DIT FFT: one stage per clock on a bank of
// 8 butterflies, 5-clock frame (load + 4 stages), fixed-point, wrap-around.

// One radix-2 butterfly: x = a + W*b, y = a - W*b, twiddle from a constant ROM.
module fft16_bfly #(
  parameter int W = 16,
  parameter int F = 8
) (
  input  logic [W-1:0] a_re, a_im, b_re, b_im,
  input  logic [2:0]   tw,
  output logic [W-1:0] x_re, x_im, y_re, y_im
);
  localparam int P = 2 * W;

  logic signed [W-1:0] w_re, w_im;
  logic signed [P-1:0] br, bi, wr, wi, p_re, p_im;
  logic [W-1:0]        m_re, m_im;

  // W^t = cos(2*pi*t/16) - j*sin(2*pi*t/16), scaled by 2^F
  always_comb begin
    w_re = W'(256);
    w_im = W'(0);
    case (tw)
      3'd0: begin w_re = W'(256);  w_im = W'(0);    end
      3'd1: begin w_re = W'(237);  w_im = W'(-98);  end
      3'd2: begin w_re = W'(181);  w_im = W'(-181); end
      3'd3: begin w_re = W'(98);   w_im = W'(-237); end
      3'd4: begin w_re = W'(0);    w_im = W'(-256); end
      3'd5: begin w_re = W'(-98);  w_im = W'(-237); end
      3'd6: begin w_re = W'(-181); w_im = W'(-181); end
      3'd7: begin w_re = W'(-237); w_im = W'(-98);  end
      default: ;
    endcase
  end

  // full-width products, floor shift of the summed product, keep low W bits
  assign br   = P'($signed(b_re));
  assign bi   = P'($signed(b_im));
  assign wr   = P'(w_re);
  assign wi   = P'(w_im);
  assign p_re = br * wr - bi * wi;
  assign p_im = br * wi + bi * wr;
  assign m_re = W'(p_re >>> F);
  assign m_im = W'(p_im >>> F);

  assign x_re = a_re + m_re;
  assign x_im = a_im + m_im;
  assign y_re = a_re - m_re;
  assign y_im = a_im - m_im;
endmodule

module fft16_pipelined #(
  parameter int WORD_SIZE = 16,
  parameter int FRACTION  = 8,
  parameter int STAGES    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fft16_pipelined_if.slave  bus
);
  localparam int W = WORD_SIZE;
  localparam logic [2:0] LAST = 3'(STAGES);

  typedef logic [15:0][W-1:0] arr_t;

  arr_t in_re, in_im, ld_re, ld_im, work_re, work_im, nxt_re, nxt_im, out_re, out_im;
  logic [2:0] phase, phase_nxt;
  logic [1:0] stage;
  logic       is_load, is_last, done;

  logic [3:0]   ia [8];
  logic [3:0]   ib [8];
  logic [W-1:0] x_re [8];
  logic [W-1:0] x_im [8];
  logic [W-1:0] y_re [8];
  logic [W-1:0] y_im [8];

  // upper index of butterfly b at stage s, and its twiddle exponent
  function automatic int a_idx(int b, int s);
    return ((b >> s) << (s + 1)) | (b & ((1 << s) - 1));
  endfunction
  function automatic int t_idx(int b, int s);
    return (b & ((1 << s) - 1)) << (3 - s);
  endfunction

  assign in_re = {bus.in15_re, bus.in14_re, bus.in13_re, bus.in12_re, bus.in11_re, bus.in10_re,
                  bus.in9_re, bus.in8_re, bus.in7_re, bus.in6_re, bus.in5_re, bus.in4_re,
                  bus.in3_re, bus.in2_re, bus.in1_re, bus.in0_re};
  assign in_im = {bus.in15_im, bus.in14_im, bus.in13_im, bus.in12_im, bus.in11_im, bus.in10_im,
                  bus.in9_im, bus.in8_im, bus.in7_im, bus.in6_im, bus.in5_im, bus.in4_im,
                  bus.in3_im, bus.in2_im, bus.in1_im, bus.in0_im};
  assign {bus.out15_re, bus.out14_re, bus.out13_re, bus.out12_re, bus.out11_re, bus.out10_re,
          bus.out9_re, bus.out8_re, bus.out7_re, bus.out6_re, bus.out5_re, bus.out4_re,
          bus.out3_re, bus.out2_re, bus.out1_re, bus.out0_re} = out_re;
  assign {bus.out15_im, bus.out14_im, bus.out13_im, bus.out12_im, bus.out11_im, bus.out10_im,
          bus.out9_im, bus.out8_im, bus.out7_im, bus.out6_im, bus.out5_im, bus.out4_im,
          bus.out3_im, bus.out2_im, bus.out1_im, bus.out0_im} = out_im;
  assign bus.o_FFT_cycle_done = done;

  // bit-reversed load order so the stages run in natural order
  for (genvar i = 0; i < 16; i++) begin : g_ld
    localparam int BR = ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
    assign ld_re[i] = in_re[BR];
    assign ld_im[i] = in_im[BR];
  end

  // phase register: 0 = load, 1..LAST = stage phase-1
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) phase <= '0;
    else        phase <= phase_nxt;
  end

  // phase sequencing with wrap after the last stage
  always_comb begin
    phase_nxt = (phase == LAST) ? 3'd0 : phase + 3'd1;
  end

  // phase decode
  always_comb begin
    is_load = (phase == 3'd0);
    is_last = (phase == LAST);
    stage   = 2'(phase - 3'd1);
  end

  for (genvar b = 0; b < 8; b++) begin : g_bf
    localparam logic [3:0] A0 = 4'(a_idx(b, 0)), A1 = 4'(a_idx(b, 1));
    localparam logic [3:0] A2 = 4'(a_idx(b, 2)), A3 = 4'(a_idx(b, 3));
    localparam logic [2:0] T0 = 3'(t_idx(b, 0)), T1 = 3'(t_idx(b, 1));
    localparam logic [2:0] T2 = 3'(t_idx(b, 2)), T3 = 3'(t_idx(b, 3));

    logic [3:0] a_sel, b_sel;
    logic [2:0] t_sel;

    // pair and twiddle routing for the current stage
    always_comb begin
      a_sel = A0;
      t_sel = T0;
      case (stage)
        2'd0: begin a_sel = A0; t_sel = T0; end
        2'd1: begin a_sel = A1; t_sel = T1; end
        2'd2: begin a_sel = A2; t_sel = T2; end
        2'd3: begin a_sel = A3; t_sel = T3; end
        default: ;
      endcase
    end

    assign b_sel = a_sel + (4'd1 << stage);
    assign ia[b] = a_sel;
    assign ib[b] = b_sel;

    fft16_bfly #(.W(W), .F(FRACTION)) u_bf (
      .a_re(work_re[a_sel]), .a_im(work_im[a_sel]),
      .b_re(work_re[b_sel]), .b_im(work_im[b_sel]),
      .tw(t_sel),
      .x_re(x_re[b]), .x_im(x_im[b]), .y_re(y_re[b]), .y_im(y_im[b])
    );
  end

  // scatter butterfly results back into their pair slots
  always_comb begin
    nxt_re = work_re;
    nxt_im = work_im;
    for (int b = 0; b < 8; b++) begin
      nxt_re[ia[b]] = x_re[b];
      nxt_im[ia[b]] = x_im[b];
      nxt_re[ib[b]] = y_re[b];
      nxt_im[ib[b]] = y_im[b];
    end
  end

  // work array update; last stage lands directly in the output bins
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      work_re <= '0;
      work_im <= '0;
      out_re  <= '0;
      out_im  <= '0;
      done    <= 1'b0;
    end else begin
      done <= is_last;
      if (is_load) begin
        work_re <= ld_re;
        work_im <= ld_im;
      end else if (is_last) begin
        out_re <= nxt_re;
        out_im <= nxt_im;
      end else begin
        work_re <= nxt_re;
        work_im <= nxt_im;
      end
    end
  end
endmodule

// File: tb/tb_fft16_pipelined.sv
// Bench for fft16_pipelined: table of frames checked against a floating-point
// DFT (or literal bins), through a scoreboard queue, plus reset sequences.
module tb_fft16_pipelined;
  localparam int W = 16;

  typedef struct {
    string name;
    int    xr[16];
    int    xi[16];
    int    er[16];
    int    ei[16];
    int    tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft16_pipelined_if #(.WORD_SIZE(W)) bus ();

  fft16_pipelined #(.WORD_SIZE(W), .FRACTION(8), .STAGES(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  logic [15:0][W-1:0] drv_re, drv_im, got_re, got_im;
  assign {bus.in15_re, bus.in14_re, bus.in13_re, bus.in12_re, bus.in11_re, bus.in10_re,
          bus.in9_re, bus.in8_re, bus.in7_re, bus.in6_re, bus.in5_re, bus.in4_re,
          bus.in3_re, bus.in2_re, bus.in1_re, bus.in0_re} = drv_re;
  assign {bus.in15_im, bus.in14_im, bus.in13_im, bus.in12_im, bus.in11_im, bus.in10_im,
          bus.in9_im, bus.in8_im, bus.in7_im, bus.in6_im, bus.in5_im, bus.in4_im,
          bus.in3_im, bus.in2_im, bus.in1_im, bus.in0_im} = drv_im;
  assign got_re = {bus.out15_re, bus.out14_re, bus.out13_re, bus.out12_re, bus.out11_re,
                   bus.out10_re, bus.out9_re, bus.out8_re, bus.out7_re, bus.out6_re,
                   bus.out5_re, bus.out4_re, bus.out3_re, bus.out2_re, bus.out1_re, bus.out0_re};
  assign got_im = {bus.out15_im, bus.out14_im, bus.out13_im, bus.out12_im, bus.out11_im,
                   bus.out10_im, bus.out9_im, bus.out8_im, bus.out7_im, bus.out6_im,
                   bus.out5_im, bus.out4_im, bus.out3_im, bus.out2_im, bus.out1_im, bus.out0_im};

  int   errs = 0;
  int   checks = 0;
  vec_t tbl[6];
  vec_t sb[$];
  vec_t last;
  bit   have_last = 1'b0;

  // compare modulo 2^16 with a +/- tolerance
  task automatic chk(input string nm, input int act, input int exp_v, input int tol);
    int d;
    checks++;
    d = $signed(16'(act - exp_v));
    if (d > tol || d < -tol) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp_v, tol);
    end
  endtask

  function automatic vec_t mk(input string nm, input int tol);
    vec_t v;
    v.name = nm;
    v.tol  = tol;
    for (int i = 0; i < 16; i++) begin
      v.xr[i] = 0; v.xi[i] = 0; v.er[i] = 0; v.ei[i] = 0;
    end
    return v;
  endfunction

  // direct floating-point DFT X[k] = sum x[n] * exp(-j*2*pi*n*k/16), rounded
  function automatic vec_t with_dft(input vec_t v);
    vec_t r;
    real  sr, si, a;
    r = v;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        a  = 2.0 * 3.14159265358979 * real'(n * k) / 16.0;
        sr = sr + real'(v.xr[n]) * $cos(a) + real'(v.xi[n]) * $sin(a);
        si = si + real'(v.xi[n]) * $cos(a) - real'(v.xr[n]) * $sin(a);
      end
      r.er[k] = $rtoi(sr >= 0.0 ? sr + 0.5 : sr - 0.5);
      r.ei[k] = $rtoi(si >= 0.0 ? si + 0.5 : si - 0.5);
    end
    return r;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 16; i++) begin
      drv_re[i] = W'($urandom);
      drv_im[i] = W'($urandom);
    end
  endtask

  // Called at a negedge: drives v, LOAD on the next edge, bins expected
  // after the 4th following edge; inputs are garbage during the stages.
  task automatic run_frame(input vec_t v);
    vec_t e;
    for (int i = 0; i < 16; i++) begin
      drv_re[i] = W'(v.xr[i]);
      drv_im[i] = W'(v.xi[i]);
    end
    sb.push_back(v);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c < 4) begin
        scramble();
        chk($sformatf("%s_done_low%0d", v.name, c), int'(bus.o_FFT_cycle_done), 0, 0);
        if (c == 2 && have_last) begin
          chk($sformatf("%s_hold0_re", v.name), int'($signed(got_re[0])), last.er[0], last.tol);
          chk($sformatf("%s_hold15_im", v.name), int'($signed(got_im[15])), last.ei[15], last.tol);
        end
      end else begin
        chk($sformatf("%s_done_pulse", v.name), int'(bus.o_FFT_cycle_done), 1, 0);
        if (bus.o_FFT_cycle_done && sb.size() > 0) begin
          e = sb.pop_front();
          for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_bin%0d_re", e.name, k), int'($signed(got_re[k])), e.er[k], e.tol);
            chk($sformatf("%s_bin%0d_im", e.name, k), int'($signed(got_im[k])), e.ei[k], e.tol);
          end
          last      = e;
          have_last = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vec_t v;

    // impulse at n=0: flat spectrum
    v = mk("impulse", 0);
    v.xr[0] = 256;
    for (int k = 0; k < 16; k++) v.er[k] = 256;
    tbl[0] = v;
    // DC: all energy in bin 0
    v = mk("dc", 0);
    for (int n = 0; n < 16; n++) v.xr[n] = 16;
    v.er[0] = 256;
    tbl[1] = v;
    // impulse at n=1: bins trace the twiddles
    v = mk("delayed", 1);
    v.xr[1] = 256;
    tbl[2] = with_dft(v);
    // sparse frame
    v = mk("sparse", 3);
    v.xr[0] = 362; v.xi[0] = 201; v.xr[1] = 362; v.xi[1] = 201;
    v.xr[3] = 362; v.xi[3] = 201; v.xr[7] = 362; v.xi[7] = 201;
    tbl[3] = with_dft(v);
    // imaginary impulse at n=2
    v = mk("imag2", 1);
    v.xi[2] = 256;
    tbl[4] = with_dft(v);
    // large DC: bin 0 = 48000 wraps, no saturation
    v = mk("wrap", 0);
    for (int n = 0; n < 16; n++) v.xr[n] = 3000;
    v.er[0] = -17536;
    tbl[5] = v;

    // reset held with nonzero inputs
    scramble();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rst_out%0d_re", k), int'($signed(got_re[k])), 0, 0);
      chk($sformatf("rst_out%0d_im", k), int'($signed(got_im[k])), 0, 0);
    end
    chk("rst_done", int'(bus.o_FFT_cycle_done), 0, 0);

    // release; first frame's done must land on the 5th edge
    rst = 1'b1;
    last = mk("zero", 0);
    have_last = 1'b1;
    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // mid-frame reset at phase 2 aborts the frame and clears outputs at once
    for (int i = 0; i < 16; i++) begin
      drv_re[i] = W'(tbl[1].xr[i]);
      drv_im[i] = W'(tbl[1].xi[i]);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out0_re", int'($signed(got_re[0])), 0, 0);
    chk("midrst_out0_im", int'($signed(got_im[0])), 0, 0);
    chk("midrst_out8_re", int'($signed(got_re[8])), 0, 0);
    chk("midrst_done", int'(bus.o_FFT_cycle_done), 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_hold_re", int'($signed(got_re[0])), 0, 0);
    rst = 1'b1;
    last = mk("zero", 0);
    have_last = 1'b1;
    run_frame(tbl[3]);
    run_frame(tbl[2]);

    chk("sb_empty", sb.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
